// File: rtl/avmm_mem_pkg.sv
// avmm_mem_pkg: shared constants and types for the Avalon-MM slave memory.
//   ADDR_W_DEF / DATA_W_DEF : default address (word) and data widths
//   addr_t / data_t          : address and data word types at default widths
//   RESET_DATA               : value driven on readdata for reset/unwritten/out-of-range
package avmm_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  localparam data_t RESET_DATA = '0;

endpackage

// File: rtl/avmm_if.sv
// avmm_if: minimal Avalon-MM bus bundle (no waitrequest, fixed read latency).
//   clk, rst_n : clock and asynchronous active-low reset (interface ports)
//   address    : word address
//   write/read : one-word-per-cycle strobes
//   writedata  : data to store
//   readdata   : registered read data returned by the slave
// Modports: master drives the strobes, slave returns readdata.
interface avmm_if
  import avmm_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clk,
  input logic rst_n
);

  logic [ADDR_W-1:0] address;
  logic              write;
  logic              read;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    input  clk, rst_n, readdata,
    output address, write, read, writedata
  );

  modport slave (
    input  clk, rst_n, address, write, read, writedata,
    output readdata
  );

endinterface

// File: rtl/avmm_mem_array.sv
// avmm_mem_array: DEPTH x DATA_W synchronous RAM with a registered read port.
//   clk   : clock
//   we    : write enable (caller guarantees addr < DEPTH)
//   re    : read enable (caller guarantees addr < DEPTH); rdata holds when low
//   addr  : word address
//   wdata : write data
//   rdata : registered read data, read-before-write on a same-address collision
// No reset on the storage or the read register so the array maps onto block RAM.
module avmm_mem_array
  import avmm_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a read in the same cycle as a write
  // to the same word captures the old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/avmm_memory.sv
// avmm_memory: single-port Avalon-MM slave memory, zero wait states, 1-cycle reads.
//   clk   : system clock
//   rst_n : asynchronous active-low reset; clears the valid vector and readdata
//   bus   : avmm_if slave modport (address, write, read, writedata, readdata)
// Words never written since the last reset, and addresses >= DEPTH, read as 0.
// Optional macro AVMM_MEM_ASSERT_EN compiles in bus protocol assertions and a cover.
module avmm_memory
  import avmm_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2**ADDR_W
) (
  input logic   clk,
  input logic   rst_n,
  avmm_if.slave bus
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic              in_range;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic [DEPTH-1:0]  valid;
  logic              hit_q;

  assign in_range = ({1'b0, bus.address} < DEPTH_LIM);

  // Gating with rst_n drops any strobe that coincides with reset.
  assign ram_we = rst_n & bus.write & in_range;
  assign ram_re = rst_n & bus.read  & in_range;

  avmm_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (bus.address),
    .wdata (bus.writedata),
    .rdata (ram_rdata)
  );

  // hit_q records whether the last read hit a written, in-range word. It is
  // sampled from valid before this cycle's write lands, matching the RAM's
  // read-before-write, and resetting it zeroes readdata immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      hit_q <= 1'b0;
    end else begin
      if (bus.read) begin
        hit_q <= in_range && valid[bus.address];
      end
      if (ram_we) begin
        valid[bus.address] <= 1'b1;
      end
    end
  end

  assign bus.readdata = hit_q ? ram_rdata : DATA_W'(RESET_DATA);

`ifdef AVMM_MEM_ASSERT_EN
  a_no_x_ctrl: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({bus.read, bus.write, bus.address}));

  a_readdata_hold: assert property (@(posedge clk) disable iff (!rst_n)
    !bus.read |=> $stable(bus.readdata));

  c_read_write: cover property (@(posedge clk) disable iff (!rst_n)
    bus.read && bus.write);
`endif

endmodule

// File: tb/tb_avmm_memory.sv
// tb_avmm_memory: scoreboard bench driving two avmm_memory instances in lockstep,
// one fully populated (DEPTH=256) and one partial (DEPTH=200).
module tb_avmm_memory;
  import avmm_mem_pkg::*;

  localparam int HALF_PERIOD = 10;
  localparam int PART_DEPTH  = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #HALF_PERIOD clk = ~clk;

  avmm_if #(.ADDR_W(8), .DATA_W(32)) bus_full (.clk(clk), .rst_n(rst_n));
  avmm_if #(.ADDR_W(8), .DATA_W(32)) bus_part (.clk(clk), .rst_n(rst_n));

  avmm_memory #(.ADDR_W(8), .DATA_W(32), .DEPTH(256)) dut_full (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_full.slave)
  );

  avmm_memory #(.ADDR_W(8), .DATA_W(32), .DEPTH(PART_DEPTH)) dut_part (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_part.slave)
  );

  int check_count = 0;
  int error_count = 0;

  logic [31:0] model_mem [256];
  bit          valid_full [256];
  bit          valid_part [256];
  logic [31:0] exp_full_q [$];
  logic [31:0] exp_part_q [$];
  logic [31:0] last_full = '0;
  logic [31:0] last_part = '0;
  bit          read_seen = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic clearModelValid();
    for (int i = 0; i < 256; i++) begin
      valid_full[i] = 1'b0;
      valid_part[i] = 1'b0;
    end
  endtask

  // Drives one bus cycle on both DUTs and records what each should return.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [7:0] addr,
                               input logic [31:0] wdata);
    @(negedge clk);
    bus_full.read = rd;  bus_full.write = wr;
    bus_full.address = addr;  bus_full.writedata = wdata;
    bus_part.read = rd;  bus_part.write = wr;
    bus_part.address = addr;  bus_part.writedata = wdata;
    if (rd) begin
      exp_full_q.push_back(valid_full[addr] ? model_mem[addr] : 32'h0);
      exp_part_q.push_back((int'(addr) < PART_DEPTH && valid_part[addr]) ?
                           model_mem[addr] : 32'h0);
    end
    if (wr) begin
      model_mem[addr]  = wdata;
      valid_full[addr] = 1'b1;
      if (int'(addr) < PART_DEPTH) valid_part[addr] = 1'b1;
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  // One-cycle reset pulse with a write strobe that must be discarded.
  task automatic pulseReset();
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    bus_full.write = 1'b1;  bus_full.address = 8'h06;  bus_full.writedata = 32'h0BADF00D;
    bus_part.write = 1'b1;  bus_part.address = 8'h06;  bus_part.writedata = 32'h0BADF00D;
    #1;
    checkOutput("midrst_full", bus_full.readdata, 32'h0);
    checkOutput("midrst_part", bus_part.readdata, 32'h0);
    clearModelValid();
    last_full = '0;
    last_part = '0;
    @(posedge clk);
    #1;
    bus_full.write = 1'b0;
    bus_part.write = 1'b0;
    #4;
    rst_n = 1'b1;
  endtask

  always @(posedge clk) read_seen <= rst_n && bus_full.read;

  // Pops one expected word per accepted read; otherwise readdata must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (read_seen) begin
        if (exp_full_q.size() == 0 || exp_part_q.size() == 0) begin
          checkOutput("sb_underflow", 32'(exp_full_q.size()), 32'd1);
        end else begin
          last_full = exp_full_q.pop_front();
          last_part = exp_part_q.pop_front();
          checkOutput("rd_full", bus_full.readdata, last_full);
          checkOutput("rd_part", bus_part.readdata, last_part);
        end
      end else begin
        checkOutput("hold_full", bus_full.readdata, last_full);
        checkOutput("hold_part", bus_part.readdata, last_part);
      end
    end
  end

  initial begin
    bus_full.read = 1'b0;  bus_full.write = 1'b0;
    bus_full.address = '0; bus_full.writedata = '0;
    bus_part.read = 1'b0;  bus_part.write = 1'b0;
    bus_part.address = '0; bus_part.writedata = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    clearModelValid();

    #75;
    rst_n = 1'b1;
    checkOutput("reset_full", bus_full.readdata, 32'h0);
    checkOutput("reset_part", bus_part.readdata, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h00, 32'h0);
    idleCycle();

    // Basic write then immediate read of the same word.
    applyStimulus(1'b0, 1'b1, 8'h10, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0);
    idleCycle();

    // Full-rate traffic across the whole address space.
    for (int i = 0; i < 256; i++) applyStimulus(1'b0, 1'b1, 8'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 256; i++) applyStimulus(1'b1, 1'b0, 8'(i), 32'h0);
    idleCycle();

    // Same-cycle read and write: old data first, new data on the next read.
    applyStimulus(1'b0, 1'b1, 8'h20, 32'h11111111);
    applyStimulus(1'b1, 1'b1, 8'h20, 32'h22222222);
    applyStimulus(1'b1, 1'b0, 8'h20, 32'h0);
    idleCycle();

    // Reset in the middle of traffic.
    applyStimulus(1'b0, 1'b1, 8'h05, 32'h55AA55AA);
    applyStimulus(1'b1, 1'b0, 8'h05, 32'h0);
    idleCycle();
    pulseReset();
    applyStimulus(1'b1, 1'b0, 8'h05, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h06, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'h10, 32'h0);
    idleCycle();

    // Out-of-range on the partial instance, in-range traffic alongside.
    applyStimulus(1'b0, 1'b1, 8'hF0, 32'hCAFEF00D);
    applyStimulus(1'b1, 1'b0, 8'hF0, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'hC7, 32'h13579BDF);
    applyStimulus(1'b0, 1'b1, 8'hC8, 32'h2468ACE0);
    applyStimulus(1'b1, 1'b0, 8'hC7, 32'h0);
    applyStimulus(1'b1, 1'b0, 8'hC8, 32'h0);
    applyStimulus(1'b1, 1'b1, 8'h40, 32'h12345678);
    applyStimulus(1'b1, 1'b0, 8'h40, 32'h0);
    idleCycle();
    idleCycle();

    for (int n = 0; n < 10 && exp_full_q.size() != 0; n++) @(negedge clk);
    checkOutput("sb_drain", 32'(exp_full_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
